div_repeated_sub: RTL and testbench

DIV_REPEATED_SUB -- requirements
Module: div_repeated_sub

---
 rtl/div_repeated_sub.sv | 113 +++++++++++
 tb/tb_div_repeated_sub.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/div_repeated_sub.sv
// Unsigned 16-bit divider by repeated subtraction over a shared operand bus.
// Optional abort port and logic enabled by defining DIV_ABORT_EN.
module div_repeated_sub (
  input  logic        clk,
  input  logic        rst,
`ifdef DIV_ABORT_EN
  input  logic        abort,
`endif
  input  logic        start,
  input  logic [15:0] data_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        div_by_zero
);

  localparam int unsigned DW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LDB  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] q_q, q_d;
  logic          dbz_q, dbz_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      q_q     <= q_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    q_d     = q_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = data_in;
          q_d     = '0;
          dbz_d   = 1'b0;
          state_d = LDB;
        end
      end
      LDB: begin
`ifdef DIV_ABORT_EN
        if (abort) state_d = IDLE;
        else
`endif
        begin
          b_d = data_in;
          if (data_in == DW'(0)) begin
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
`ifdef DIV_ABORT_EN
        if (abort) state_d = IDLE;
        else
`endif
        if (a_q >= b_q) begin
          a_d = a_q - b_q;
          q_d = q_q + DW'(1);
        end else begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Status flags registered alongside the state they describe
    busy_d = (state_d == LDB) || (state_d == RUN);
    done_d = (state_d == DONE);
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = q_q;
  assign remainder   = a_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_repeated_sub.sv
// Scoreboard bench for div_repeated_sub: driver queues expected results and
// done timing, a negedge monitor checks them whenever done is seen.
module tb_div_repeated_sub;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] data_in;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;
`ifdef DIV_ABORT_EN
  logic        abort;
`endif

  div_repeated_sub dut (
    .clk         (clk),
    .rst         (rst),
`ifdef DIV_ABORT_EN
    .abort       (abort),
`endif
    .start       (start),
    .data_in     (data_in),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending result (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_quotient"},  32'(quotient),    32'(e.q));
        check({e.name, "_remainder"}, 32'(remainder),   32'(e.r));
        check({e.name, "_dbz"},       32'(div_by_zero), 32'(e.dbz));
        check({e.name, "_done_cycle"}, 32'(cyc),        32'(e.cyc));
        check({e.name, "_busy_low"},  32'(busy),        32'd0);
      end
    end
  end

  // Issue a division starting at the current negedge; returns at the
  // negedge following the start-sampling edge with the divisor on the bus.
  task automatic do_div(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eq, input logic [15:0] er,
                        input logic edbz, input int lat, input bit push,
                        input string name);
    int k;
    bit seen;
    start   = 1'b1;
    data_in = a;
    seen    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (busy === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_start: got busy=0 expected busy=1 within 4 cycles", name);
    end
    k       = cyc;
    start   = 1'b0;
    data_in = b;
    if (push) sb.push_back('{q: eq, r: er, dbz: edbz, cyc: k + lat, name: name});
  endtask

  task automatic wait_done(input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, budget);
    end
  endtask

  task automatic check_idle_zero(input string name);
    check({name, "_busy"},      32'(busy),        32'd0);
    check({name, "_done"},      32'(done),        32'd0);
    check({name, "_quotient"},  32'(quotient),    32'd0);
    check({name, "_remainder"}, 32'(remainder),   32'd0);
    check({name, "_dbz"},       32'(div_by_zero), 32'd0);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    data_in = 16'd0;
`ifdef DIV_ABORT_EN
    abort   = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_idle_zero("reset");

    do_div(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 16, 1'b1, "d100_7");
    wait_done(40, "d100_7");
    repeat (3) @(negedge clk);
    check("hold_quotient",  32'(quotient),  32'd14);
    check("hold_remainder", 32'(remainder), 32'd2);

    do_div(16'd5, 16'd9, 16'd0, 16'd5, 1'b0, 2, 1'b1, "d5_9");
    wait_done(20, "d5_9");
    @(negedge clk);

    do_div(16'd9, 16'd0, 16'd0, 16'd9, 1'b1, 1, 1'b1, "d9_0");
    wait_done(20, "d9_0");
    repeat (2) @(negedge clk);
    check("hold_dbz", 32'(div_by_zero), 32'd1);

    do_div(16'd0, 16'd4, 16'd0, 16'd0, 1'b0, 2, 1'b1, "d0_4");
    wait_done(20, "d0_4");
    @(negedge clk);

    // start pulses and bus noise while busy must be ignored
    do_div(16'd50, 16'd5, 16'd10, 16'd0, 1'b0, 12, 1'b1, "d50_5");
    @(negedge clk);
    start   = 1'b1;
    data_in = 16'd999;
    repeat (3) @(negedge clk);
    start   = 1'b0;
    wait_done(40, "d50_5");

    // back-to-back: start raised in the done cycle, held until accepted
    do_div(16'd7, 16'd7, 16'd1, 16'd0, 1'b0, 3, 1'b1, "d7_7");
    wait_done(20, "d7_7");
    do_div(16'd13, 16'd4, 16'd3, 16'd1, 1'b0, 5, 1'b1, "d13_4");
    wait_done(20, "d13_4");
    @(negedge clk);

    // reset mid-RUN discards the operation
    do_div(16'd1000, 16'd3, 16'd0, 16'd0, 1'b0, 0, 1'b0, "d1000_rst");
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_zero("midrun_reset");
    repeat (2) @(negedge clk);
    do_div(16'd20, 16'd6, 16'd3, 16'd2, 1'b0, 5, 1'b1, "d20_6");
    wait_done(20, "d20_6");
    @(negedge clk);

`ifdef DIV_ABORT_EN
    // abort in the fifth RUN cycle returns to IDLE without done
    do_div(16'd1000, 16'd3, 16'd0, 16'd0, 1'b0, 0, 1'b0, "d1000_abort");
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    repeat (5) @(negedge clk);
    do_div(16'd20, 16'd6, 16'd3, 16'd2, 1'b0, 5, 1'b1, "d20_6_after_abort");
    wait_done(20, "d20_6_after_abort");
    @(negedge clk);
`endif

    do_div(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 65537, 1'b1, "d65535_1");
    wait_done(70000, "d65535_1");
    repeat (3) @(negedge clk);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
